fp_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined single-precision multiply unit (`multiply`: IEEE-754 in, IEEE-754 out, fixed pipeline latency, `ce` low holds it in reset) among N requesters. It accepts at most one operand pair per cycle and drives the unit's operands and `ce`. It tracks each in-flight product with a requester tag, then returns each result to the requester that issued it. It sits between the solver's per-lane update engines and the shared multiplier.

---
 rtl/fp_mul_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one pipelined FP multiplier among N_REQ requesters
// Grants one operand pair per cycle and routes each product back to its issuer after MUL_LATENCY+1 edges.
module fp_mul_arbiter #(
  parameter int          N_REQ             = 4,
  parameter int          MUL_LATENCY       = 6,
  parameter logic [31:0] ISSUE_COUNT_RESET = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_ce,
  input  logic [31:0]          mul_result,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [31:0]          issue_count
);

  localparam int              ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int              DEPTH      = MUL_LATENCY + 1;
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  grant_id;
  logic             xfer;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  int               scan_idx;
  logic [DEPTH-1:0] tag_valid;
  logic [ID_W-1:0]  tag_id [DEPTH];

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    xfer      = 1'b0;
    scan_idx  = 0;
    if (mul_ce) begin
      for (int k = 1; k <= N_REQ; k++) begin
        scan_idx = (int'(last) + k) % N_REQ;
        if (!xfer && req_valid[ID_W'(scan_idx)]) begin
          xfer                      = 1'b1;
          grant_id                  = ID_W'(scan_idx);
          req_ready[ID_W'(scan_idx)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_ce      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      last        <= LAST_RESET;
      issue_count <= ISSUE_COUNT_RESET;
      tag_valid   <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id[k] <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      busy        <= 1'b0;
    end else begin
      mul_ce <= 1'b1;
      if (xfer) begin
        mul_a       <= sel_a;
        mul_b       <= sel_b;
        last        <= grant_id;
        issue_count <= issue_count + 32'd1;
      end
      // Tag stage k tracks the product issued k+1 edges ago; the last stage lines up with mul_result.
      tag_valid <= {tag_valid[DEPTH-2:0], xfer};
      tag_id[0] <= grant_id;
      for (int k = 1; k < DEPTH; k++) tag_id[k] <= tag_id[k-1];
      if (tag_valid[DEPTH-1]) begin
        rsp_valid <= N_REQ'(1) << tag_id[DEPTH-1];
        rsp_data  <= mul_result;
      end else begin
        rsp_valid <= '0;
      end
      busy <= xfer | (|tag_valid[DEPTH-2:0]);
    end
  end

endmodule
